// File: rtl/mouse_bus_pkg.sv
// Shared definitions for the mouse bus slave: register offsets, snapshot layout, default depth.
package mouse_bus_pkg;

    localparam logic [7:0] OFS_STATUS = 8'd0;
    localparam logic [7:0] OFS_X      = 8'd1;
    localparam logic [7:0] OFS_Y      = 8'd2;
    localparam logic [7:0] OFS_Z      = 8'd3;
    localparam logic [7:0] OFS_COUNT  = 8'd4;

    localparam int STATUS_W = 4;
    localparam int AXIS_W   = 8;
    localparam int SNAP_W   = STATUS_W + 3 * AXIS_W;

    localparam int DEFAULT_FIFO_DEPTH = 4;

    typedef struct packed {
        logic [STATUS_W-1:0] status;
        logic [AXIS_W-1:0]   x;
        logic [AXIS_W-1:0]   y;
        logic [AXIS_W-1:0]   z;
    } snapshot_t;

endpackage

// File: rtl/mouse_snapshot_fifo.sv
// Snapshot queue for mouse packets. MOUSE_SNAPSHOT_FIFO_EN selects a FIFO_DEPTH-entry queue;
// otherwise a single holding register that every new packet overwrites.
module mouse_snapshot_fifo
    import mouse_bus_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic      CLK,
    input  logic      RESET,
    input  logic      pushEn,
    input  logic      popEn,
    input  snapshot_t pushData,
    output snapshot_t headData,
    output logic [2:0] count,
    output logic      ovf,
    output logic      pushAccepted
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [CNT_W-1:0] countReg;
    logic             ovfReg;

    assign count = 3'(countReg);
    assign ovf   = ovfReg;

`ifdef MOUSE_SNAPSHOT_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    snapshot_t        memReg [FIFO_DEPTH];
    logic [PTR_W-1:0] headReg;
    logic [PTR_W-1:0] tailReg;
    logic             empty;
    logic             full;
    logic             doPush;
    logic             doPop;

    assign empty  = (countReg == '0);
    assign full   = (countReg == CNT_W'(FIFO_DEPTH));
    assign doPop  = popEn && !empty;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign doPush = pushEn && (!full || doPop);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            headReg  <= '0;
            tailReg  <= '0;
            countReg <= '0;
            ovfReg   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                memReg[i] <= '0;
            end
        end else begin
            if (doPush) begin
                memReg[tailReg] <= pushData;
                tailReg         <= tailReg + PTR_W'(1);
            end
            if (doPop) begin
                headReg <= headReg + PTR_W'(1);
            end
            countReg <= countReg + CNT_W'(doPush) - CNT_W'(doPop);
            if (popEn) begin
                ovfReg <= 1'b0;
            end else if (pushEn && !doPush) begin
                ovfReg <= 1'b1;
            end
        end
    end

    assign headData     = empty ? '0 : memReg[headReg];
    assign pushAccepted = doPush;
`else
    snapshot_t holdReg;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            holdReg  <= '0;
            countReg <= '0;
            ovfReg   <= 1'b0;
        end else begin
            if (pushEn) begin
                holdReg  <= pushData;
                countReg <= CNT_W'(1);
            end else if (popEn) begin
                countReg <= '0;
            end
            // Overwriting an entry software never popped is the overflow case here.
            if (popEn) begin
                ovfReg <= 1'b0;
            end else if (pushEn && countReg != '0) begin
                ovfReg <= 1'b1;
            end
        end
    end

    assign headData     = (countReg != '0) ? holdReg : '0;
    assign pushAccepted = pushEn;
`endif

endmodule

// File: rtl/mouse_bus_interface.sv
// Processor-bus slave exposing queued mouse packets as read registers with an interrupt.
// Queue depth is honoured only when MOUSE_SNAPSHOT_FIFO_EN is defined.
module mouse_bus_interface
    import mouse_bus_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR  = 8'hA0,
    parameter int         FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] MOUSE_STATUS,
    input  logic [7:0] MOUSE_X,
    input  logic [7:0] MOUSE_Y,
    input  logic [7:0] MOUSE_Z,
    input  logic       MOUSE_NEW,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    inout  wire  [7:0] BUS_DATA,
    output logic       BUS_INTERRUPT_RAISE,
    input  logic       BUS_INTERRUPT_ACK
);

`ifdef MOUSE_SNAPSHOT_FIFO_EN
    localparam int EFF_DEPTH = FIFO_DEPTH;
`else
    localparam int EFF_DEPTH = (FIFO_DEPTH > 0) ? 1 : 1;
`endif

    snapshot_t  pushData;
    snapshot_t  headData;
    logic [2:0] count;
    logic       ovf;
    logic       pushAccepted;
    logic [7:0] offset;
    logic       readEn;
    logic       popEn;
    logic [7:0] readMux;
    logic [7:0] readDataReg;
    logic       driveReg;
    logic       raiseReg;

    assign pushData = {MOUSE_STATUS, MOUSE_X, MOUSE_Y, MOUSE_Z};

    // Unsigned wrap makes addresses below BASE_ADDR land far outside the window.
    assign offset = BUS_ADDR - BASE_ADDR;
    assign readEn = !BUS_WE && (offset <= OFS_COUNT);
    assign popEn  = BUS_WE && (offset == OFS_COUNT);

    mouse_snapshot_fifo #(
        .FIFO_DEPTH(EFF_DEPTH)
    ) u_fifo (
        .CLK         (CLK),
        .RESET       (RESET),
        .pushEn      (MOUSE_NEW),
        .popEn       (popEn),
        .pushData    (pushData),
        .headData    (headData),
        .count       (count),
        .ovf         (ovf),
        .pushAccepted(pushAccepted)
    );

    always_comb begin
        readMux = 8'h00;
        case (offset)
            OFS_STATUS: readMux = {ovf, 3'b000, headData.status};
            OFS_X:      readMux = headData.x;
            OFS_Y:      readMux = headData.y;
            OFS_Z:      readMux = headData.z;
            OFS_COUNT:  readMux = {ovf, 4'b0000, count};
            default:    readMux = 8'h00;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            readDataReg <= 8'h00;
            driveReg    <= 1'b0;
            raiseReg    <= 1'b0;
        end else begin
            driveReg <= readEn;
            if (readEn) begin
                readDataReg <= readMux;
            end
            // A new packet wins over a coincident acknowledge.
            if (pushAccepted) begin
                raiseReg <= 1'b1;
            end else if (BUS_INTERRUPT_ACK) begin
                raiseReg <= 1'b0;
            end
        end
    end

    assign BUS_DATA            = driveReg ? readDataReg : 8'hzz;
    assign BUS_INTERRUPT_RAISE = raiseReg;

endmodule

// File: tb/tb_mouse_bus_interface.sv
// Self-checking bench for mouse_bus_interface: queue-based reference model plus directed reads.
module tb_mouse_bus_interface;

    localparam logic [7:0] BASE = 8'hA0;
`ifdef MOUSE_SNAPSHOT_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [3:0] MOUSE_STATUS = 4'h0;
    logic [7:0] MOUSE_X = 8'h00;
    logic [7:0] MOUSE_Y = 8'h00;
    logic [7:0] MOUSE_Z = 8'h00;
    logic       MOUSE_NEW = 1'b0;
    logic [7:0] BUS_ADDR = 8'h00;
    logic       BUS_WE = 1'b0;
    logic       BUS_INTERRUPT_ACK = 1'b0;
    wire  [7:0] BUS_DATA;
    wire        BUS_INTERRUPT_RAISE;

    int tests = 0;
    int fails = 0;

    // An undriven bus floats high so "released" is observable as 8'hFF.
    for (genvar gi = 0; gi < 8; gi++) begin : g_pull
        pullup (BUS_DATA[gi]);
    end

    mouse_bus_interface #(
        .BASE_ADDR (BASE),
        .FIFO_DEPTH(4)
    ) dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .MOUSE_STATUS       (MOUSE_STATUS),
        .MOUSE_X            (MOUSE_X),
        .MOUSE_Y            (MOUSE_Y),
        .MOUSE_Z            (MOUSE_Z),
        .MOUSE_NEW          (MOUSE_NEW),
        .BUS_ADDR           (BUS_ADDR),
        .BUS_WE             (BUS_WE),
        .BUS_DATA           (BUS_DATA),
        .BUS_INTERRUPT_RAISE(BUS_INTERRUPT_RAISE),
        .BUS_INTERRUPT_ACK  (BUS_INTERRUPT_ACK)
    );

    always #5 CLK = ~CLK;

    // Reference model: a plain queue of packed {status,x,y,z} snapshots.
    logic [27:0] mq[$];
    logic        mOvf = 1'b0;
    logic        mRaise = 1'b0;
    logic        mDrive = 1'b0;
    logic [7:0]  mData = 8'h00;
    logic [7:0]  mOff;
    bit          mPop;
    bit          mAcc;

    function automatic logic [7:0] mRead(input logic [7:0] off);
        logic [27:0] h;
        h = (mq.size() > 0) ? mq[0] : 28'h0;
        case (off)
            8'd0:    return {mOvf, 3'b000, h[27:24]};
            8'd1:    return h[23:16];
            8'd2:    return h[15:8];
            8'd3:    return h[7:0];
            8'd4:    return {mOvf, 4'b0000, 3'(mq.size())};
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mq.delete();
            mOvf   = 1'b0;
            mRaise = 1'b0;
            mDrive = 1'b0;
            mData  = 8'h00;
        end else begin
            mOff   = BUS_ADDR - BASE;
            mDrive = !BUS_WE && (mOff <= 8'd4);
            if (mDrive) mData = mRead(mOff);
            mPop = BUS_WE && (mOff == 8'd4);
            if (DEPTH == 1) begin
                mAcc = MOUSE_NEW;
                if (mPop) mOvf = 1'b0;
                else if (MOUSE_NEW && mq.size() == 1) mOvf = 1'b1;
                if (mPop || MOUSE_NEW) mq.delete();
            end else begin
                mAcc = MOUSE_NEW && (mq.size() < DEPTH || (mPop && mq.size() > 0));
                if (mPop) mOvf = 1'b0;
                else if (MOUSE_NEW && !mAcc) mOvf = 1'b1;
                if (mPop && mq.size() > 0) void'(mq.pop_front());
            end
            if (mAcc) mq.push_back({MOUSE_STATUS, MOUSE_X, MOUSE_Y, MOUSE_Z});
            if (mAcc) mRaise = 1'b1;
            else if (BUS_INTERRUPT_ACK) mRaise = 1'b0;
        end
    end

    always @(negedge CLK) begin
        tests++;
        if (BUS_INTERRUPT_RAISE !== mRaise) begin
            fails++;
            $display("FAIL model_raise t=%0t got %b want %b", $time, BUS_INTERRUPT_RAISE, mRaise);
        end
        tests++;
        if (BUS_DATA !== (mDrive ? mData : 8'hFF)) begin
            fails++;
            $display("FAIL model_bus t=%0t got %h want %h", $time, BUS_DATA, mDrive ? mData : 8'hFF);
        end
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %h want %h", name, got, want);
        end else begin
            $display("[TB] %s = %h ok", name, got);
        end
    endtask

    task automatic step(input bit nw, input logic [7:0] x, input bit we,
                        input logic [7:0] addr, input bit ack);
        @(posedge CLK);
        #2;
        MOUSE_NEW         = nw;
        MOUSE_X           = x;
        BUS_WE            = we;
        BUS_ADDR          = addr;
        BUS_INTERRUPT_ACK = ack;
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic push(input logic [7:0] x);
        step(1'b1, x, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, 8'h00, 1'b1, BASE + 8'd4, 1'b0);
    endtask

    task automatic ack();
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic readChk(input logic [7:0] off, input logic [7:0] want, input string name);
        step(1'b0, 8'h00, 1'b0, BASE + off, 1'b0);
        idle();
        @(negedge CLK);
        check(name, BUS_DATA, want);
    endtask

    task automatic raiseChk(input logic want, input string name);
        @(negedge CLK);
        check(name, {7'd0, BUS_INTERRUPT_RAISE}, {7'd0, want});
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #2 RESET = 1'b0;

        // T1: reset state
        @(negedge CLK);
        check("t1_raise", {7'd0, BUS_INTERRUPT_RAISE}, 8'h00);
        check("t1_bus_released", BUS_DATA, 8'hFF);
        readChk(8'd4, 8'h00, "t1_count");
        readChk(8'd0, 8'h00, "t1_status");

        // T2: single packet, register map, ack, pop
        MOUSE_STATUS = 4'h1;
        MOUSE_Y      = 8'h3C;
        MOUSE_Z      = 8'h80;
        push(8'h50);
        idle();
        raiseChk(1'b1, "t2_raise");
        readChk(8'd0, 8'h01, "t2_status");
        readChk(8'd1, 8'h50, "t2_x");
        readChk(8'd2, 8'h3C, "t2_y");
        readChk(8'd3, 8'h80, "t2_z");
        readChk(8'd4, 8'h01, "t2_count");
        MOUSE_STATUS = 4'h0;
        MOUSE_Y      = 8'h00;
        MOUSE_Z      = 8'h00;
        ack();
        idle();
        raiseChk(1'b0, "t2_ack");
        pop();
        readChk(8'd4, 8'h00, "t2_popped");

`ifdef MOUSE_SNAPSHOT_FIFO_EN
        // T3: overflow of a 4-deep queue, then drain in order
        for (int i = 1; i <= 5; i++) push(8'(i));
        readChk(8'd4, 8'h84, "t3_count_ovf");
        readChk(8'd1, 8'h01, "t3_head_x1");
        readChk(8'd0, 8'h80, "t3_status_ovf");
        for (int i = 2; i <= 4; i++) begin
            pop();
            readChk(8'd1, 8'(i), "t3_head_x");
        end
        readChk(8'd0, 8'h00, "t3_ovf_cleared");
        pop();
        readChk(8'd4, 8'h00, "t3_drained");
        ack();

        // T4: push and pop together while full
        for (int i = 0; i < 4; i++) push(8'h11 + 8'(i));
        step(1'b1, 8'h15, 1'b1, BASE + 8'd4, 1'b0);
        readChk(8'd4, 8'h04, "t4_count_kept");
        readChk(8'd1, 8'h12, "t4_head_advanced");
        repeat (4) pop();
        readChk(8'd4, 8'h00, "t4_drained");
        ack();
`else
        // T6: holding register overwrite sets overflow
        push(8'h07);
        push(8'h09);
        readChk(8'd1, 8'h09, "t6_x_latest");
        readChk(8'd4, 8'h81, "t6_count_ovf");
        pop();
        readChk(8'd4, 8'h00, "t6_popped");
        ack();
`endif

        // T5: ack coincident with a new packet, then pop past empty
        push(8'h33);
        step(1'b1, 8'h34, 1'b0, 8'h00, 1'b1);
        idle();
        raiseChk(1'b1, "t5_raise_held");
        repeat (3) pop();
        readChk(8'd4, 8'h00, "t5_empty_pop");
        ack();
        idle();
        raiseChk(1'b0, "t5_ack");

        // Reset in the middle of traffic discards everything
        push(8'h44);
        idle();
        #1 RESET = 1'b1;
        raiseChk(1'b0, "rst_raise");
        repeat (2) @(posedge CLK);
        #2 RESET = 1'b0;
        readChk(8'd4, 8'h00, "rst_count");
        readChk(8'd1, 8'h00, "rst_x");

        repeat (2) idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
